// File: rtl/apple_eat_tracker.sv
// Apple-eaten detector: one ARMED/HIT/WAIT_MOVE FSM per apple and a saturating score.
// Optional macro APPLE_EAT_TIMEOUT_EN lets WAIT_MOVE time out after 4 body ticks.
module apple_eat_tracker (
    input  logic       system_clk,
    input  logic       nreset,
    input  logic       clk_body,
    input  logic       enable_in,
    input  logic [3:0] snake_head_x,
    input  logic [3:0] snake_head_y,
    input  logic [7:0] apple_location1,
    input  logic [7:0] apple_location2,
    output logic       good_collision,
    output logic       good_collision2,
    output logic [7:0] score,
    output logic       busy
);

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        HIT       = 2'd1,
        WAIT_MOVE = 2'd2
    } state_t;

    state_t     state1_q, state1_d, state2_q, state2_d;
    logic [7:0] eaten_loc1_q, eaten_loc1_d, eaten_loc2_q, eaten_loc2_d;
    logic [7:0] score_q, score_d;
    logic [7:0] head_loc;
    logic       match1, match2, same_loc;
    logic [1:0] hit_count;
    logic [8:0] score_sum;

`ifdef APPLE_EAT_TIMEOUT_EN
    logic [2:0] wait_cnt1_q, wait_cnt1_d, wait_cnt2_q, wait_cnt2_d;
`endif

    assign head_loc = {snake_head_y, snake_head_x};
    assign match1   = (head_loc == apple_location1);
    assign match2   = (head_loc == apple_location2);
    // Two apples on one square: apple 1 takes the hit, apple 2 stays armed.
    assign same_loc = (apple_location1 == apple_location2);

    always_comb begin
        state1_d     = state1_q;
        eaten_loc1_d = eaten_loc1_q;
`ifdef APPLE_EAT_TIMEOUT_EN
        wait_cnt1_d  = wait_cnt1_q;
`endif
        case (state1_q)
            ARMED: begin
                if (clk_body && match1) begin
                    state1_d     = HIT;
                    eaten_loc1_d = apple_location1;
                end
            end
            HIT: begin
                state1_d = WAIT_MOVE;
`ifdef APPLE_EAT_TIMEOUT_EN
                wait_cnt1_d = 3'd0;
`endif
            end
            WAIT_MOVE: begin
                if (apple_location1 != eaten_loc1_q) begin
                    state1_d = ARMED;
                end
`ifdef APPLE_EAT_TIMEOUT_EN
                else if (clk_body) begin
                    wait_cnt1_d = wait_cnt1_q + 3'd1;
                    if (wait_cnt1_q == 3'd3) state1_d = ARMED;
                end
`endif
            end
            default: state1_d = ARMED;
        endcase
    end

    always_comb begin
        state2_d     = state2_q;
        eaten_loc2_d = eaten_loc2_q;
`ifdef APPLE_EAT_TIMEOUT_EN
        wait_cnt2_d  = wait_cnt2_q;
`endif
        case (state2_q)
            ARMED: begin
                if (enable_in && clk_body && match2 && !same_loc) begin
                    state2_d     = HIT;
                    eaten_loc2_d = apple_location2;
                end
            end
            HIT: begin
                state2_d = WAIT_MOVE;
`ifdef APPLE_EAT_TIMEOUT_EN
                wait_cnt2_d = 3'd0;
`endif
            end
            WAIT_MOVE: begin
                if (apple_location2 != eaten_loc2_q) begin
                    state2_d = ARMED;
                end
`ifdef APPLE_EAT_TIMEOUT_EN
                else if (clk_body) begin
                    wait_cnt2_d = wait_cnt2_q + 3'd1;
                    if (wait_cnt2_q == 3'd3) state2_d = ARMED;
                end
`endif
            end
            default: state2_d = ARMED;
        endcase
        // Single-apple mode parks FSM2; a HIT already showing still completes this cycle.
        if (!enable_in) state2_d = ARMED;
    end

    always_comb begin
        hit_count = {1'b0, state1_q == HIT} + {1'b0, state2_q == HIT};
        score_sum = {1'b0, score_q} + {7'b0, hit_count};
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            state1_q     <= ARMED;
            state2_q     <= ARMED;
            eaten_loc1_q <= 8'h55;
            eaten_loc2_q <= 8'h55;
            score_q      <= 8'h00;
`ifdef APPLE_EAT_TIMEOUT_EN
            wait_cnt1_q  <= 3'd0;
            wait_cnt2_q  <= 3'd0;
`endif
        end else begin
            state1_q     <= state1_d;
            state2_q     <= state2_d;
            eaten_loc1_q <= eaten_loc1_d;
            eaten_loc2_q <= eaten_loc2_d;
            score_q      <= score_d;
`ifdef APPLE_EAT_TIMEOUT_EN
            wait_cnt1_q  <= wait_cnt1_d;
            wait_cnt2_q  <= wait_cnt2_d;
`endif
        end
    end

    // Outputs decode the registered states, so an asynchronous reset clears them at once.
    assign good_collision  = (state1_q == HIT);
    assign good_collision2 = (state2_q == HIT);
    assign busy            = (state1_q != ARMED) || (state2_q != ARMED);
    assign score           = score_q;

endmodule
